// File: rtl/move_commit.sv
// move_commit: validates a packed move word, probes the target board cell
// and commits the tile code to board memory, reporting status and count.
module move_commit #(
    parameter int MAX_ROW   = 20,
    parameter int MAX_COL   = 20,
    parameter int MAX_TILES = 400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] move_in,
    input  logic        move_valid,
    output logic        move_ready,
    input  logic [9:0]  m,
    input  logic [9:0]  n,
    output logic        rd_en,
    output logic [9:0]  rd_row,
    output logic [9:0]  rd_col,
    input  logic [2:0]  rd_data,
    output logic        wr_en,
    output logic [9:0]  wr_row,
    output logic [9:0]  wr_col,
    output logic [2:0]  wr_data,
    output logic        done,
    output logic [1:0]  status,
    output logic [8:0]  tile_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_WRITE,
        S_DONE
    } state_e;

    localparam logic [9:0] ROW_CAP  = 10'(MAX_ROW);
    localparam logic [9:0] COL_CAP  = 10'(MAX_COL);
    localparam logic [8:0] TILE_CAP = 9'(MAX_TILES);

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_TYPE  = 2'b01;
    localparam logic [1:0] ST_BOUND = 2'b10;
    localparam logic [1:0] ST_OCC   = 2'b11;

    state_e      state_q, state_d;
    logic [1:0]  type_q, type_d;
    logic [9:0]  row_q, row_d;
    logic [9:0]  col_q, col_d;
    logic [9:0]  m_q, m_d;
    logic [9:0]  n_q, n_d;
    logic [1:0]  status_q, status_d;
    logic [8:0]  count_q, count_d;

    logic [9:0]  row_lim;
    logic [9:0]  col_lim;
    logic        out_of_bounds;
    logic        cell_busy;

    // Effective board extent: the live size clamped to the RAM geometry.
    always_comb begin
        row_lim       = (m_q < ROW_CAP) ? m_q : ROW_CAP;
        col_lim       = (n_q < COL_CAP) ? n_q : COL_CAP;
        out_of_bounds = (row_q >= row_lim) || (col_q >= col_lim);
        cell_busy     = (rd_data != 3'b000);
    end

    // State and latched-move registers; reset drops any move in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            type_q   <= 2'b00;
            row_q    <= '0;
            col_q    <= '0;
            m_q      <= '0;
            n_q      <= '0;
            status_q <= ST_OK;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            row_q    <= row_d;
            col_q    <= col_d;
            m_q      <= m_d;
            n_q      <= n_d;
            status_q <= status_d;
            count_q  <= count_d;
        end
    end

    // Next-state, strobes and status/count updates per state.
    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        row_d      = row_q;
        col_d      = col_q;
        m_d        = m_q;
        n_d        = n_q;
        status_d   = status_q;
        count_d    = count_q;
        move_ready = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                move_ready = 1'b1;
                if (move_valid) begin
                    type_d  = move_in[21:20];
                    col_d   = move_in[19:10];
                    row_d   = move_in[9:0];
                    m_d     = m;
                    n_d     = n;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (type_q == 2'b00) begin
                    status_d = ST_TYPE;
                    state_d  = S_DONE;
                end else if (out_of_bounds) begin
                    status_d = ST_BOUND;
                    state_d  = S_DONE;
                end else begin
                    rd_en   = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (cell_busy) begin
                    status_d = ST_OCC;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_en    = 1'b1;
                status_d = ST_OK;
                if (count_q != TILE_CAP) begin
                    count_d = count_q + 9'd1;
                end
                state_d  = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Addresses and data follow the latched move; only meaningful with strobes.
    always_comb begin
        rd_row     = row_q;
        rd_col     = col_q;
        wr_row     = row_q;
        wr_col     = col_q;
        wr_data    = {1'b0, type_q};
        status     = status_q;
        tile_count = count_q;
    end

endmodule

// File: tb/tb_move_commit.sv
// tb_move_commit: directed stimulus against a cycle-offset model of
// move_commit, plus literal checks on the observed sequence.
module tb_move_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic [21:0] move_in;
    logic        move_valid;
    logic        move_ready;
    logic [9:0]  m;
    logic [9:0]  n;
    logic        rd_en;
    logic [9:0]  rd_row;
    logic [9:0]  rd_col;
    logic [2:0]  rd_data;
    logic        wr_en;
    logic [9:0]  wr_row;
    logic [9:0]  wr_col;
    logic [2:0]  wr_data;
    logic        done;
    logic [1:0]  status;
    logic [8:0]  tile_count;

    logic [2:0]  rd_resp;

    int checks = 0;
    int errors = 0;

    move_commit dut (
        .clk        (clk),
        .rst        (rst),
        .move_in    (move_in),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .m          (m),
        .n          (n),
        .rd_en      (rd_en),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .done       (done),
        .status     (status),
        .tile_count (tile_count)
    );

    always #5 clk = ~clk;

    // Board RAM stand-in: answers one cycle after a read strobe.
    always @(posedge clk) begin
        rd_data <= rd_en ? rd_resp : 3'b111;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at cycle", name, act, exp);
        end
    endtask

    // Transaction model: outcome decided at accept, events placed by offset.
    int  cyc = 0;
    bit  armed = 0;
    bit  mbusy = 0;
    bit  was_idle;
    int  mk, mres, mdonek;
    int  mcnt = 0;
    int  mstat = 0;
    int  mrow, mcol, mtype;
    int  rl, cl;
    int  acc_cyc[$];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            armed = 1;
            mbusy = 0;
            mcnt  = 0;
            mstat = 0;
        end else begin
            was_idle = !mbusy;
            if (mbusy) begin
                mk++;
                if (mk == mdonek) mstat = mres;
                if (mk == 4 && mres == 0) mcnt = (mcnt < 400) ? mcnt + 1 : 400;
                if (mk > mdonek) mbusy = 0;
            end
            if (was_idle && move_valid) begin
                mtype = int'(move_in[21:20]);
                mcol  = int'(move_in[19:10]);
                mrow  = int'(move_in[9:0]);
                rl    = (int'(m) < 20) ? int'(m) : 20;
                cl    = (int'(n) < 20) ? int'(n) : 20;
                if (mtype == 0) mres = 1;
                else if (mrow >= rl || mcol >= cl) mres = 2;
                else if (rd_resp != 3'b000) mres = 3;
                else mres = 0;
                mdonek = (mres == 0) ? 4 : (mres == 3) ? 3 : 2;
                mbusy  = 1;
                mk     = 1;
                acc_cyc.push_back(cyc);
            end
        end
    end

    // Per-cycle comparison, plus event logging for literal checks.
    int wr_seen = 0;
    int rd_seen = 0;
    int done_seen = 0;
    int last_wr_rel = 0;
    int last_done_rel = 0;
    int last_rd_rel = 0;
    int acc_last;

    always @(posedge clk) begin
        #1;
        if (armed) begin
            chk("ready", int'(move_ready), int'(!mbusy));
            chk("rd_en", int'(rd_en),
                int'(mbusy && mk == 1 && (mres == 0 || mres == 3)));
            chk("wr_en", int'(wr_en), int'(mbusy && mk == 3 && mres == 0));
            chk("done", int'(done), int'(mbusy && mk == mdonek));
            chk("status", int'(status), mstat);
            chk("tile_count", int'(tile_count), mcnt);
            acc_last = (acc_cyc.size() > 0) ? acc_cyc[$] : 0;
            if (rd_en) begin
                rd_seen++;
                last_rd_rel = cyc - acc_last + 1;
                chk("rd_row", int'(rd_row), mrow);
                chk("rd_col", int'(rd_col), mcol);
            end
            if (wr_en) begin
                wr_seen++;
                last_wr_rel = cyc - acc_last + 1;
                chk("wr_row", int'(wr_row), mrow);
                chk("wr_col", int'(wr_col), mcol);
                chk("wr_data", int'(wr_data), mtype);
            end
            if (done) begin
                done_seen++;
                last_done_rel = cyc - acc_last + 1;
            end
        end
    end

    task automatic wait_ready(input string name);
        for (int i = 0; i < 20 && !move_ready; i++) @(negedge clk);
        if (!move_ready) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for move_ready got 0 expected 1", name);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        move_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_move(input logic [1:0] t, input logic [9:0] c,
                           input logic [9:0] r, input logic [9:0] mm,
                           input logic [9:0] nn, input logic [2:0] occ);
        @(negedge clk);
        rd_resp    = occ;
        move_in    = {t, c, r};
        m          = mm;
        n          = nn;
        move_valid = 1'b1;
        wait_ready("accept");
        @(posedge clk);
        @(negedge clk);
        move_valid = 1'b0;
        m          = 10'd0;
        n          = 10'd0;
        move_in    = '0;
        wait_ready("finish");
    endtask

    task automatic b2b(input int cnt);
        @(negedge clk);
        rd_resp    = 3'b000;
        m          = 10'd20;
        n          = 10'd20;
        move_valid = 1'b1;
        for (int i = 0; i < cnt; i++) begin
            move_in = {2'b01, 10'(i % 7), 10'(i % 9)};
            wait_ready("b2b");
            @(posedge clk);
            @(negedge clk);
        end
        move_valid = 1'b0;
        wait_ready("b2b_end");
    endtask

    int w0, d0, r0, a0;

    initial begin
        rst        = 1'b1;
        move_valid = 1'b0;
        move_in    = '0;
        m          = 10'd0;
        n          = 10'd0;
        rd_resp    = 3'b000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rd_row", int'(rd_row), 0);
        chk("reset_wr_col", int'(wr_col), 0);
        chk("reset_wr_data", int'(wr_data), 0);
        chk("reset_ready", int'(move_ready), 1);

        do_move(2'b01, 10'd3, 10'd5, 10'd10, 10'd10, 3'b000);
        chk("t1_count", int'(tile_count), 1);
        chk("t1_wr_rel", last_wr_rel, 3);
        chk("t1_done_rel", last_done_rel, 4);
        chk("t1_rd_rel", last_rd_rel, 1);
        chk("t1_status", int'(status), 0);

        w0 = wr_seen; r0 = rd_seen;
        do_move(2'b00, 10'd2, 10'd2, 10'd10, 10'd10, 3'b000);
        chk("t2_status", int'(status), 1);
        chk("t2_done_rel", last_done_rel, 2);
        chk("t2_no_wr", wr_seen - w0, 0);
        chk("t2_no_rd", rd_seen - r0, 0);
        chk("t2_count", int'(tile_count), 1);

        do_move(2'b10, 10'd4, 10'd10, 10'd10, 10'd10, 3'b000);
        chk("t3a_status", int'(status), 2);
        chk("t3a_done_rel", last_done_rel, 2);
        do_move(2'b10, 10'd4, 10'd20, 10'd30, 10'd30, 3'b000);
        chk("t3b_status", int'(status), 2);
        chk("t3b_done_rel", last_done_rel, 2);
        chk("t3_no_wr", wr_seen - w0, 0);
        chk("t3_no_rd", rd_seen - r0, 0);

        do_move(2'b11, 10'd1, 10'd1, 10'd10, 10'd10, 3'b010);
        chk("t4_status", int'(status), 3);
        chk("t4_done_rel", last_done_rel, 3);
        chk("t4_no_wr", wr_seen - w0, 0);
        chk("t4_rd", rd_seen - r0, 1);
        chk("t4_count", int'(tile_count), 1);

        do_reset();
        a0 = acc_cyc.size();
        b2b(3);
        chk("t5_count", int'(tile_count), 3);
        chk("t5_accepts", acc_cyc.size() - a0, 3);
        chk("t5_gap1", acc_cyc[a0 + 1] - acc_cyc[a0], 5);
        chk("t5_gap2", acc_cyc[a0 + 2] - acc_cyc[a0 + 1], 5);

        @(negedge clk);
        rst        = 1'b1;
        move_valid = 1'b1;
        move_in    = {2'b01, 10'd2, 10'd2};
        m          = 10'd10;
        n          = 10'd10;
        a0         = acc_cyc.size();
        @(negedge clk);
        rst        = 1'b0;
        move_valid = 1'b0;
        chk("rv_ready", int'(move_ready), 1);
        chk("rv_count", int'(tile_count), 0);
        chk("rv_no_accept", acc_cyc.size() - a0, 0);

        do_move(2'b01, 10'd6, 10'd7, 10'd10, 10'd10, 3'b000);
        w0 = wr_seen; d0 = done_seen;
        @(negedge clk);
        rd_resp    = 3'b000;
        move_in    = {2'b10, 10'd2, 10'd3};
        m          = 10'd10;
        n          = 10'd10;
        move_valid = 1'b1;
        wait_ready("t6");
        @(posedge clk);
        @(negedge clk);
        move_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_ready", int'(move_ready), 1);
        chk("t6_count", int'(tile_count), 0);
        repeat (4) @(negedge clk);
        chk("t6_no_wr", wr_seen - w0, 0);
        chk("t6_no_done", done_seen - d0, 0);
        chk("t6_status", int'(status), 0);

        b2b(402);
        chk("t7_saturate", int'(tile_count), 400);
        do_move(2'b01, 10'd0, 10'd0, 10'd20, 10'd20, 3'b000);
        chk("t7_hold", int'(tile_count), 400);
        chk("t7_status", int'(status), 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_commit.md
# move_commit

Consumer end of the valid-move path: takes one packed 22-bit move word ({tile type, col, row}, the same format the move generator emits), validates it, checks the target board cell through a synchronous-read port, and writes the tile code into board memory. It sits between move selection and the board RAM, and reports a per-move status plus a running placed-tile count to the game controller.

## Interface
- MAX_ROW, 20, row count of the board RAM; row index must be < min(m, MAX_ROW)
- MAX_COL, 20, column count of the board RAM; col index must be < min(n, MAX_COL)
- MAX_TILES, 400, saturation value of tile_count
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- move_in  in  22  [21:20] type (01 plus, 10 slash, 11 bslash, 00 illegal), [19:10] col, [9:0] row
- move_valid  in  1  move_in is valid
- move_ready  out  1  block can accept a move
- m  in  10  current board row extent, sampled at accept
- n  in  10  current board column extent, sampled at accept
- rd_en  out  1  board read strobe
- rd_row, rd_col  out  10 each  board read address
- rd_data  in  3  cell contents, valid the cycle after rd_en; 000 = empty
- wr_en  out  1  board write strobe, one cycle
- wr_row, wr_col  out  10 each  board write address
- wr_data  out  3  {1'b0, type}
- done  out  1  one-cycle pulse, status valid
- status  out  2  00 ok, 01 illegal type, 10 out of bounds, 11 occupied
- tile_count  out  9  tiles written since reset

## Operation
- States: IDLE, CHECK, READ, WRITE, DONE.
- IDLE: move_ready=1. On move_valid && move_ready, latch move_in, m, n; go CHECK.
- CHECK: type==00 -> status 01, DONE. Else row >= min(m,MAX_ROW) or col >= min(n,MAX_COL) -> status 10, DONE. Else assert rd_en with latched row/col, go READ. Type check has priority over bounds.
- READ: sample rd_data. Nonzero -> status 11, DONE. Zero -> WRITE.
- WRITE: wr_en=1 for exactly this cycle, wr_row/wr_col = latched row/col, wr_data={1'b0,type}; tile_count += 1 unless already MAX_TILES (saturates, no wrap); status 00; go DONE.
- DONE: done=1, status held; go IDLE.
- move_ready is 0 in every state except IDLE; move_valid outside IDLE is ignored (no buffering).
- rd_en, wr_en, done are 0 outside their own state; addresses/wr_data may hold the latched values but are don't-care when strobes are low.
- status holds its last value until the next DONE.
- m or n changing after accept has no effect on the move in flight.

## Timing
- Reset values: move_ready=1 (state IDLE) in the cycle after rst deasserts; rd_en=0, wr_en=0, done=0, status=00, tile_count=0, addresses and wr_data=0.
- Accept edge = cycle 0. CHECK in cycle 1, rd_en high in cycle 1, rd_data sampled in cycle 2.
- Success: wr_en in cycle 3, done in cycle 4, move_ready high in cycle 5 (5-cycle throughput).
- Illegal type / out of bounds: done in cycle 2, no rd_en, no wr_en; ready in cycle 3.
- Occupied: rd_en cycle 1, done cycle 3, no wr_en; ready cycle 4.
- rst asserted in any state: next cycle is IDLE with reset values; an in-flight move is dropped, no wr_en and no done issued after the reset edge; tile_count cleared.
- rst and move_valid in the same cycle: reset wins, move not accepted.

## Test plan
- Reset, then move_in={01,col 3,row 5}, m=n=10, rd_data=000 -> rd_en cycle 1 at (5,3); wr_en cycle 3, wr_data=001; done cycle 4, status 00; tile_count=1.
- move_in={00,2,2} -> done cycle 2, status 01, no rd_en/wr_en; tile_count unchanged.
- m=10, move_in={10,col 4,row 10}; then m=30, n=30, row 20 -> both status 10 (second via MAX_ROW clamp), done cycle 2, no strobes.
- move_in={11,1,1}, rd_data=010 in cycle 2 -> done cycle 3, status 11, no wr_en.
- Back-to-back valid held high with 3 legal moves -> accepts exactly every 5 cycles, move_ready low in between, tile_count 3; preload count near MAX_TILES and confirm saturation at 400.
- rst raised in cycle 2 of a legal move -> no wr_en, no done, tile_count=0, move_ready=1 the cycle after.
